pipeline_ctrl: RTL and testbench

PIPELINE_CTRL -- requirements
Module: pipeline_ctrl

---
 rtl/pipeline_ctrl.sv | 161 ++++++++++++++++
 tb/tb_pipeline_ctrl.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_ctrl.sv
// Pipeline run/step/halt controller with register-file preload and writeback port arbitration.
// Control outputs are Moore decodes of the state; the write port is a combinational mux.
module pipeline_ctrl #(
    parameter int unsigned NB_BITS = 32,
    parameter int unsigned NB_REG  = 5,
    parameter int unsigned NB_CYC  = 16,
    parameter logic [5:0]  HALT_OP = 6'b111111
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic [2:0]         i_cmd,
    input  logic               i_cmd_valid,
    output logic               o_cmd_ready,
    input  logic [NB_REG-1:0]  i_cmd_reg,
    input  logic [NB_BITS-1:0] i_cmd_data,
    input  logic [NB_BITS-1:0] i_instr,
    input  logic [NB_BITS-1:0] i_wb_data,
    input  logic [NB_REG-1:0]  i_reg_dst,
    input  logic               i_wb_rf_webn,
    output logic [NB_BITS-1:0] o_wb_data,
    output logic [NB_REG-1:0]  o_reg_dst,
    output logic               o_wb_rf_webn,
    output logic               o_pc_we,
    output logic               o_if_id_we,
    output logic               o_halted,
    output logic [2:0]         o_state,
    output logic [NB_CYC-1:0]  o_cycle_cnt,
    output logic               o_cmd_err,
    output logic               o_wb_conflict
);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_PRELOAD = 3'd1,
        ST_RUN     = 3'd2,
        ST_STEP    = 3'd3,
        ST_HALT    = 3'd4
    } state_t;

    localparam logic [2:0] CMD_NOP     = 3'd0;
    localparam logic [2:0] CMD_RUN     = 3'd1;
    localparam logic [2:0] CMD_STEP    = 3'd2;
    localparam logic [2:0] CMD_HALT    = 3'd3;
    localparam logic [2:0] CMD_PRELOAD = 3'd4;
    localparam logic [2:0] CMD_CLEAR   = 3'd5;

    state_t               state, state_nxt;
    state_t               ret_state, ret_state_nxt;
    logic [NB_CYC-1:0]    cnt, cnt_nxt, cnt_inc;
    logic [NB_REG-1:0]    pre_reg, pre_reg_nxt;
    logic [NB_BITS-1:0]   pre_data, pre_data_nxt;
    logic                 err, err_nxt;
    logic                 accept;
    logic                 halt_op_hit;
    logic                 unused_instr;

    assign unused_instr = ^i_instr;
    assign halt_op_hit  = (i_instr[31:26] == HALT_OP);
    assign accept       = i_cmd_valid && o_cmd_ready;
    assign cnt_inc      = (cnt == {NB_CYC{1'b1}}) ? cnt : cnt + NB_CYC'(1);

    // State and datapath registers
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state     <= ST_IDLE;
            ret_state <= ST_IDLE;
            cnt       <= '0;
            pre_reg   <= '0;
            pre_data  <= '0;
            err       <= 1'b0;
        end else begin
            state     <= state_nxt;
            ret_state <= ret_state_nxt;
            cnt       <= cnt_nxt;
            pre_reg   <= pre_reg_nxt;
            pre_data  <= pre_data_nxt;
            err       <= err_nxt;
        end
    end

    // Next-state, counter and preload latch logic
    always_comb begin
        state_nxt     = state;
        ret_state_nxt = ret_state;
        cnt_nxt       = cnt;
        pre_reg_nxt   = pre_reg;
        pre_data_nxt  = pre_data;
        err_nxt       = 1'b0;
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    case (i_cmd)
                        CMD_NOP, CMD_HALT: ;
                        CMD_RUN:   state_nxt = ST_RUN;
                        CMD_STEP:  state_nxt = ST_STEP;
                        CMD_PRELOAD: begin
                            state_nxt     = ST_PRELOAD;
                            ret_state_nxt = ST_IDLE;
                            pre_reg_nxt   = i_cmd_reg;
                            pre_data_nxt  = i_cmd_data;
                        end
                        CMD_CLEAR: cnt_nxt = '0;
                        default:   err_nxt = 1'b1;
                    endcase
                end
            end
            ST_PRELOAD: state_nxt = ret_state;
            ST_RUN: begin
                cnt_nxt = cnt_inc;
                if (halt_op_hit) state_nxt = ST_HALT;
                if (accept) begin
                    case (i_cmd)
                        CMD_NOP, CMD_RUN: ;
                        CMD_HALT:  state_nxt = ST_HALT;
                        CMD_CLEAR: cnt_nxt = '0;
                        default:   err_nxt = 1'b1;
                    endcase
                end
            end
            ST_STEP: begin
                cnt_nxt   = cnt_inc;
                state_nxt = ST_HALT;
            end
            ST_HALT: begin
                if (accept) begin
                    case (i_cmd)
                        CMD_NOP, CMD_HALT: ;
                        CMD_RUN:   state_nxt = ST_RUN;
                        CMD_STEP:  state_nxt = ST_STEP;
                        CMD_PRELOAD: begin
                            state_nxt     = ST_PRELOAD;
                            ret_state_nxt = ST_HALT;
                            pre_reg_nxt   = i_cmd_reg;
                            pre_data_nxt  = i_cmd_data;
                        end
                        CMD_CLEAR: begin
                            state_nxt = ST_IDLE;
                            cnt_nxt   = '0;
                        end
                        default:   err_nxt = 1'b1;
                    endcase
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Moore decodes; the controller owns the register-file port only while preloading
    assign o_cmd_ready   = (state == ST_IDLE) || (state == ST_RUN) || (state == ST_HALT);
    assign o_pc_we       = (state == ST_RUN) || (state == ST_STEP);
    assign o_if_id_we    = o_pc_we;
    assign o_halted      = (state == ST_HALT);
    assign o_state       = state;
    assign o_cycle_cnt   = cnt;
    assign o_cmd_err     = err;
    assign o_wb_conflict = (state == ST_PRELOAD) && i_wb_rf_webn;
    assign o_wb_rf_webn  = (state == ST_PRELOAD) ? 1'b1     : i_wb_rf_webn;
    assign o_reg_dst     = (state == ST_PRELOAD) ? pre_reg  : i_reg_dst;
    assign o_wb_data     = (state == ST_PRELOAD) ? pre_data : i_wb_data;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed bench for pipeline_ctrl: a vector table for single-edge behaviour plus
// hand-written sequences for run/halt, stepping, preload conflicts, reset and saturation.
module tb_pipeline_ctrl;

    localparam logic [2:0] C_NOP = 3'd0, C_RUN = 3'd1, C_STEP = 3'd2, C_HALT = 3'd3,
                           C_PRE = 3'd4, C_CLR = 3'd5;
    localparam logic [31:0] IW = 32'hDEAD_BEEF;
    localparam logic [4:0]  ID = 5'd3;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [2:0]  cmd = '0;
    logic        cmd_valid = 1'b0;
    logic [4:0]  cmd_reg = '0;
    logic [31:0] cmd_data = '0;
    logic [31:0] instr = '0;
    logic [31:0] wb_data = IW;
    logic [4:0]  reg_dst = ID;
    logic        wb_webn = 1'b0;

    logic        cmd_ready, wb_webn_o, pc_we, if_id_we, halted, cmd_err, wb_conflict;
    logic [31:0] wb_data_o;
    logic [4:0]  reg_dst_o;
    logic [2:0]  state;
    logic [15:0] cycle_cnt;

    logic [2:0]  sat_cmd = '0;
    logic        sat_valid = 1'b0;
    logic        sat_ready, sat_webn, sat_pc_we, sat_if_id_we, sat_halted, sat_err, sat_conflict;
    logic [31:0] sat_wb_data;
    logic [4:0]  sat_reg_dst;
    logic [2:0]  sat_state;
    logic [3:0]  sat_cnt;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    pipeline_ctrl dut (
        .i_clk(clk), .i_rst(rst_n), .i_cmd(cmd), .i_cmd_valid(cmd_valid),
        .o_cmd_ready(cmd_ready), .i_cmd_reg(cmd_reg), .i_cmd_data(cmd_data),
        .i_instr(instr), .i_wb_data(wb_data), .i_reg_dst(reg_dst),
        .i_wb_rf_webn(wb_webn), .o_wb_data(wb_data_o), .o_reg_dst(reg_dst_o),
        .o_wb_rf_webn(wb_webn_o), .o_pc_we(pc_we), .o_if_id_we(if_id_we),
        .o_halted(halted), .o_state(state), .o_cycle_cnt(cycle_cnt),
        .o_cmd_err(cmd_err), .o_wb_conflict(wb_conflict)
    );

    pipeline_ctrl #(.NB_CYC(4)) dut_sat (
        .i_clk(clk), .i_rst(rst_n), .i_cmd(sat_cmd), .i_cmd_valid(sat_valid),
        .o_cmd_ready(sat_ready), .i_cmd_reg(cmd_reg), .i_cmd_data(cmd_data),
        .i_instr(instr), .i_wb_data(wb_data), .i_reg_dst(reg_dst),
        .i_wb_rf_webn(wb_webn), .o_wb_data(sat_wb_data), .o_reg_dst(sat_reg_dst),
        .o_wb_rf_webn(sat_webn), .o_pc_we(sat_pc_we), .o_if_id_we(sat_if_id_we),
        .o_halted(sat_halted), .o_state(sat_state), .o_cycle_cnt(sat_cnt),
        .o_cmd_err(sat_err), .o_wb_conflict(sat_conflict)
    );

    typedef struct {
        logic [2:0]  cmd;
        logic        valid;
        logic [4:0]  creg;
        logic [31:0] cdata;
        logic [2:0]  st;
        logic        en;
        logic        hlt;
        logic [15:0] cnt;
        logic        err;
        logic        rdy;
        logic        wbwe;
        logic [4:0]  dst;
        logic [31:0] wdata;
    } vec_t;

    function automatic vec_t mk(input logic [2:0] c, input logic v, input logic [4:0] r,
                                input logic [31:0] d, input logic [2:0] st, input logic en,
                                input logic h, input logic [15:0] n, input logic e,
                                input logic rdy, input logic we, input logic [4:0] dst,
                                input logic [31:0] wd);
        vec_t x;
        x.cmd = c; x.valid = v; x.creg = r; x.cdata = d; x.st = st; x.en = en; x.hlt = h;
        x.cnt = n; x.err = e; x.rdy = rdy; x.wbwe = we; x.dst = dst; x.wdata = wd;
        return x;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [2:0] c);
        cmd = c;
        cmd_valid = 1'b1;
        step();
        cmd_valid = 1'b0;
    endtask

    vec_t vecs[16];
    int   en_cycles;

    initial begin
        vecs[0]  = mk(C_PRE, 1, 5'd1,  32'd1, 3'd1, 0, 0, 0, 0, 0, 1, 5'd1,  32'd1);
        vecs[1]  = mk(C_NOP, 0, 5'd0,  32'd0, 3'd0, 0, 0, 0, 0, 1, 0, ID,    IW);
        vecs[2]  = mk(C_PRE, 1, 5'd2,  32'd2, 3'd1, 0, 0, 0, 0, 0, 1, 5'd2,  32'd2);
        vecs[3]  = mk(C_NOP, 0, 5'd0,  32'd0, 3'd0, 0, 0, 0, 0, 1, 0, ID,    IW);
        vecs[4]  = mk(C_PRE, 1, 5'd10, 32'd8, 3'd1, 0, 0, 0, 0, 0, 1, 5'd10, 32'd8);
        vecs[5]  = mk(C_RUN, 1, 5'd0,  32'd0, 3'd0, 0, 0, 0, 0, 1, 0, ID,    IW);
        vecs[6]  = mk(3'd6,  1, 5'd0,  32'd0, 3'd0, 0, 0, 0, 1, 1, 0, ID,    IW);
        vecs[7]  = mk(C_NOP, 0, 5'd0,  32'd0, 3'd0, 0, 0, 0, 0, 1, 0, ID,    IW);
        vecs[8]  = mk(C_CLR, 1, 5'd0,  32'd0, 3'd0, 0, 0, 0, 0, 1, 0, ID,    IW);
        vecs[9]  = mk(C_HALT,1, 5'd0,  32'd0, 3'd0, 0, 0, 0, 0, 1, 0, ID,    IW);
        vecs[10] = mk(C_STEP,1, 5'd0,  32'd0, 3'd3, 1, 0, 0, 0, 0, 0, ID,    IW);
        vecs[11] = mk(C_NOP, 0, 5'd0,  32'd0, 3'd4, 0, 1, 1, 0, 1, 0, ID,    IW);
        vecs[12] = mk(C_NOP, 1, 5'd0,  32'd0, 3'd4, 0, 1, 1, 0, 1, 0, ID,    IW);
        vecs[13] = mk(3'd7,  1, 5'd0,  32'd0, 3'd4, 0, 1, 1, 1, 1, 0, ID,    IW);
        vecs[14] = mk(C_CLR, 1, 5'd0,  32'd0, 3'd0, 0, 0, 0, 0, 1, 0, ID,    IW);
        vecs[15] = mk(C_NOP, 0, 5'd0,  32'd0, 3'd0, 0, 0, 0, 0, 1, 0, ID,    IW);

        // Reset values while rst_n is held low
        #2;
        check("rst_state", 32'(state), 32'd0);
        check("rst_cnt", 32'(cycle_cnt), 32'd0);
        check("rst_ready", 32'(cmd_ready), 32'd1);
        check("rst_pc_we", 32'(pc_we), 32'd0);
        check("rst_halted", 32'(halted), 32'd0);
        check("rst_err", 32'(cmd_err), 32'd0);
        check("rst_conflict", 32'(wb_conflict), 32'd0);
        step();
        rst_n = 1'b1;

        for (int i = 0; i < 16; i++) begin
            cmd = vecs[i].cmd; cmd_valid = vecs[i].valid;
            cmd_reg = vecs[i].creg; cmd_data = vecs[i].cdata;
            step();
            check($sformatf("v%0d_state", i), 32'(state), 32'(vecs[i].st));
            check($sformatf("v%0d_pc_we", i), 32'(pc_we), 32'(vecs[i].en));
            check($sformatf("v%0d_if_id_we", i), 32'(if_id_we), 32'(vecs[i].en));
            check($sformatf("v%0d_halted", i), 32'(halted), 32'(vecs[i].hlt));
            check($sformatf("v%0d_cnt", i), 32'(cycle_cnt), 32'(vecs[i].cnt));
            check($sformatf("v%0d_err", i), 32'(cmd_err), 32'(vecs[i].err));
            check($sformatf("v%0d_ready", i), 32'(cmd_ready), 32'(vecs[i].rdy));
            check($sformatf("v%0d_wb_webn", i), 32'(wb_webn_o), 32'(vecs[i].wbwe));
            check($sformatf("v%0d_reg_dst", i), 32'(reg_dst_o), 32'(vecs[i].dst));
            check($sformatf("v%0d_wb_data", i), wb_data_o, vecs[i].wdata);
        end
        cmd_valid = 1'b0;

        // RUN for 20 cycles, HALT accepted on the 20th edge
        en_cycles = 0;
        send(C_RUN);
        for (int i = 0; i < 20; i++) begin
            if (pc_we && if_id_we) en_cycles++;
            if (i == 19) begin cmd = C_HALT; cmd_valid = 1'b1; end
            step();
        end
        cmd_valid = 1'b0;
        check("run20_en_cycles", 32'(en_cycles), 32'd20);
        check("run20_cnt", 32'(cycle_cnt), 32'd20);
        check("run20_halted", 32'(halted), 32'd1);
        check("run20_pc_we", 32'(pc_we), 32'd0);

        // Three single steps from HALT
        for (int k = 0; k < 3; k++) begin
            send(C_STEP);
            check($sformatf("step%0d_state", k), 32'(state), 32'd3);
            check($sformatf("step%0d_en", k), 32'(pc_we && if_id_we), 32'd1);
            check($sformatf("step%0d_ready", k), 32'(cmd_ready), 32'd0);
            step();
            check($sformatf("step%0d_back", k), 32'(state), 32'd4);
            check($sformatf("step%0d_en_off", k), 32'(pc_we), 32'd0);
        end
        check("step3_cnt", 32'(cycle_cnt), 32'd23);

        // PRELOAD from HALT preempting a writeback write to r29
        wb_webn = 1'b1; reg_dst = 5'd29; cmd_reg = 5'd5; cmd_data = 32'h55AA;
        send(C_PRE);
        check("conf_state", 32'(state), 32'd1);
        check("conf_webn", 32'(wb_webn_o), 32'd1);
        check("conf_dst", 32'(reg_dst_o), 32'd5);
        check("conf_data", wb_data_o, 32'h55AA);
        check("conf_pulse", 32'(wb_conflict), 32'd1);
        step();
        check("conf_ret", 32'(state), 32'd4);
        check("conf_pulse_off", 32'(wb_conflict), 32'd0);
        check("conf_pass_dst", 32'(reg_dst_o), 32'd29);
        wb_webn = 1'b0; reg_dst = ID;

        // HALT opcode still in IF/ID: RUN enters RUN then re-halts on the next edge
        instr = 32'hFC00_0000;
        send(C_RUN);
        check("rehalt_run", 32'(state), 32'd2);
        step();
        check("rehalt_halt", 32'(state), 32'd4);
        check("rehalt_cnt", 32'(cycle_cnt), 32'd24);
        instr = '0;
        send(C_CLR);
        check("clr_state", 32'(state), 32'd0);
        check("clr_cnt", 32'(cycle_cnt), 32'd0);

        // Halt opcode arriving in the 7th RUN cycle
        send(C_RUN);
        for (int i = 0; i < 7; i++) begin
            if (i == 6) instr = 32'hFC00_0000;
            step();
        end
        check("op_halt_state", 32'(state), 32'd4);
        check("op_halt_cnt", 32'(cycle_cnt), 32'd7);
        check("op_halt_en", 32'(pc_we), 32'd0);
        instr = '0;
        step();
        check("op_halt_stay", 32'(state), 32'd4);
        send(C_CLR);

        // Out-of-state STEP and CLEAR during RUN
        send(C_RUN);
        send(C_STEP);
        check("run_step_state", 32'(state), 32'd2);
        check("run_step_err", 32'(cmd_err), 32'd1);
        check("run_step_cnt", 32'(cycle_cnt), 32'd1);
        step();
        check("run_step_err_off", 32'(cmd_err), 32'd0);
        send(C_CLR);
        check("run_clr_state", 32'(state), 32'd2);
        check("run_clr_cnt", 32'(cycle_cnt), 32'd0);
        step();
        check("run_clr_cnt_inc", 32'(cycle_cnt), 32'd1);

        // Asynchronous reset mid-RUN
        #2 rst_n = 1'b0;
        #1;
        check("arst_state", 32'(state), 32'd0);
        check("arst_cnt", 32'(cycle_cnt), 32'd0);
        check("arst_pc_we", 32'(pc_we), 32'd0);
        check("arst_ready", 32'(cmd_ready), 32'd1);
        step();
        rst_n = 1'b1;

        // Reset mid-PRELOAD drops the write; reset mid-STEP drops the enable
        cmd_reg = 5'd7; cmd_data = 32'h77;
        send(C_PRE);
        check("pre_mid", 32'(wb_webn_o), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("pre_abort_webn", 32'(wb_webn_o), 32'd0);
        check("pre_abort_dst", 32'(reg_dst_o), 32'(ID));
        step();
        rst_n = 1'b1;
        send(C_STEP);
        check("step_mid", 32'(pc_we), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("step_abort_en", 32'(pc_we), 32'd0);
        step();
        rst_n = 1'b1;
        step();
        check("step_abort_idle", 32'(state), 32'd0);
        check("step_abort_cnt", 32'(cycle_cnt), 32'd0);

        // 4-bit counter saturates at 15 over a 20-cycle run
        sat_cmd = C_RUN; sat_valid = 1'b1;
        step();
        sat_valid = 1'b0;
        for (int i = 0; i < 15; i++) step();
        check("sat_cnt15", 32'(sat_cnt), 32'd15);
        for (int i = 0; i < 5; i++) step();
        check("sat_cnt_hold", 32'(sat_cnt), 32'd15);
        check("sat_state", 32'(sat_state), 32'd2);
        check("sat_en", 32'(sat_pc_we && sat_if_id_we), 32'd1);
        check("sat_err", 32'(sat_err | sat_conflict | sat_halted), 32'd0);
        check("sat_ready", 32'(sat_ready), 32'd1);
        check("sat_wb", 32'(sat_webn), 32'(wb_webn));
        check("sat_wb_data", sat_wb_data, wb_data);
        check("sat_reg_dst", 32'(sat_reg_dst), 32'(reg_dst));
        #2 rst_n = 1'b0;
        #1;
        check("sat_arst_cnt", 32'(sat_cnt), 32'd0);
        check("sat_arst_state", 32'(sat_state), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
